// File: rtl/jtcop_objdma.sv
// jtcop_objdma -- object RAM DMA engine.
//
// Copies the whole object RAM (2^AW words) into one bank of the object line
// buffer frame store each time the main CPU raises obj_copy. Reads are issued
// one per cen-qualified clock. Each write lands one clock after its read,
// when the synchronous RAM data is valid. One further request can be queued
// while a copy is in flight. Any requests beyond that one are dropped.
//
// Build option:
//   JTCOP_OBJDMA_VBWAIT_EN  defined: a queued copy only starts while LVBL is
//                           low (inside vertical blank). Once a copy has
//                           started it runs to completion.
//                           undefined: a copy starts on the first cen cycle
//                           and LVBL is ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cen             DMA clock enable (one read issued per cen)
//   LVBL            vertical blank, active low
//   obj_copy        copy request level; its rising edge is the request
//   mixpsel         destination bank, sampled when the copy starts
//   src_addr        object RAM read address
//   src_dout        object RAM read data (1-clock latency)
//   buf_addr        destination address {bank, word}
//   buf_din         destination write data
//   buf_we          destination write strobe, one clock wide
//   busy            high while the engine is not idle
//   done            one-clock pulse on the clock after the last write
//
// state | meaning
// IDLE  | no copy in progress, waiting for a request edge
// WAIT  | request accepted, waiting for cen (and blank, when enabled) to start
// COPY  | issuing one read per cen; writes trail the reads by one clock
// FLUSH | last read issued; its write lands and the engine exits

module jtcop_objdma #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          LVBL,
    input  logic          obj_copy,
    input  logic          mixpsel,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_dout,
    output logic [AW:0]   buf_addr,
    output logic [DW-1:0] buf_din,
    output logic          buf_we,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_COPY  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t      st, st_nxt;
    logic        obj_l;
    logic        req;
    logic        pending, pend_nxt;
    logic        bank;
    logic        go;
    logic        issue;
    logic        iss;       // a read was issued on the previous clock
    logic        flush_d;   // delays done to the clock after the last write
    logic        start_ok;
    logic [AW:0] rd_cnt, rd_nxt;

    assign req    = obj_copy & ~obj_l;
    assign rd_nxt = rd_cnt + 1'b1;

`ifdef JTCOP_OBJDMA_VBWAIT_EN
    assign start_ok = ~LVBL;
`else
    logic unused_lvbl;
    assign unused_lvbl = LVBL;
    assign start_ok    = 1'b1;
`endif

    always_comb begin
        st_nxt   = st;
        pend_nxt = pending;
        go       = 1'b0;
        issue    = 1'b0;
        case (st)
            ST_IDLE: begin
                if (req) st_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A request here merges into the copy that has not started yet
                if (cen && start_ok) begin
                    go     = 1'b1;
                    st_nxt = ST_COPY;
                end
            end
            ST_COPY: begin
                if (req) pend_nxt = 1'b1;
                if (cen) begin
                    issue = 1'b1;
                    // MSB of the incremented count marks the last address
                    if (rd_nxt[AW]) st_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (pending || req) begin
                    pend_nxt = 1'b0;
                    st_nxt   = ST_WAIT;
                end else begin
                    st_nxt   = ST_IDLE;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            obj_l    <= 1'b0;
            pending  <= 1'b0;
            bank     <= 1'b0;
            rd_cnt   <= '0;
            src_addr <= '0;
            iss      <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            flush_d  <= 1'b0;
            done     <= 1'b0;
        end else begin
            st      <= st_nxt;
            obj_l   <= obj_copy;
            pending <= pend_nxt;
            if (go) begin
                bank   <= mixpsel;
                rd_cnt <= '0;
            end
            if (issue) begin
                src_addr <= rd_cnt[AW-1:0];
                rd_cnt   <= rd_nxt;
            end
            // src_addr still holds the issued address when the data returns,
            // since it only moves on the next issue
            iss    <= issue;
            buf_we <= iss;
            if (iss) buf_addr <= {bank, src_addr};
            flush_d <= (st == ST_FLUSH);
            done    <= flush_d;
        end
    end

    // RAM data is valid exactly during the write clock; hold 0 otherwise
    assign buf_din = buf_we ? src_dout : '0;
    assign busy    = (st != ST_IDLE);

endmodule

// File: tb/tb_jtcop_objdma.sv
module tb_jtcop_objdma;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cen = 1'b1;
    logic          LVBL;
    logic          obj_copy;
    logic          mixpsel;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_dout = '0;
    logic [AW:0]   buf_addr;
    logic [DW-1:0] buf_din;
    logic          buf_we;
    logic          busy;
    logic          done;

    jtcop_objdma #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .LVBL     (LVBL),
        .obj_copy (obj_copy),
        .mixpsel  (mixpsel),
        .src_addr (src_addr),
        .src_dout (src_dout),
        .buf_addr (buf_addr),
        .buf_din  (buf_din),
        .buf_we   (buf_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [16];
    always @(posedge clk) src_dout <= mem[src_addr];

    logic gate_cen = 1'b0;
    always @(negedge clk) cen = gate_cen ? (cyc % 4 == 0) : 1'b1;

    // write / done / busy logger
    int            wr_n, done_n, busy_n, done_cyc;
    logic [AW:0]   wr_addr [64];
    logic [DW-1:0] wr_data [64];
    int            wr_cyc  [64];

    always @(negedge clk) begin
        if (!rst) begin
            if (buf_we) begin
                if (wr_n < 64) begin
                    wr_addr[wr_n] = buf_addr;
                    wr_data[wr_n] = buf_din;
                    wr_cyc[wr_n]  = cyc;
                end
                wr_n = wr_n + 1;
            end
            if (done) begin
                done_n   = done_n + 1;
                done_cyc = cyc;
            end
            if (busy) busy_n = busy_n + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int t_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_log();
        wr_n = 0; done_n = 0; busy_n = 0; done_cyc = 0;
    endtask

    task automatic pulse_req(input int n);
        @(negedge clk);
        obj_copy = 1'b1;
        t_req    = cyc;
        repeat (n) @(negedge clk);
        obj_copy = 1'b0;
    endtask

    task automatic wait_wr(input int target, input string tag);
        int k = 0;
        while (wr_n < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(wr_n >= target), 1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (done_n < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done_n >= target), 1);
    endtask

    int n_at;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hA500 + 16'(i);
        rst = 1'b1; obj_copy = 1'b0; mixpsel = 1'b0;
`ifdef JTCOP_OBJDMA_VBWAIT_EN
        LVBL = 1'b0;
`else
        LVBL = 1'b1;
`endif
        clear_log();
        repeat (3) @(negedge clk);
        chk("rst buf_we",   32'(buf_we),   0);
        chk("rst busy",     32'(busy),     0);
        chk("rst done",     32'(done),     0);
        chk("rst src_addr", 32'(src_addr), 0);
        chk("rst buf_addr", 32'(buf_addr), 0);
        chk("rst buf_din",  32'(buf_din),  0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic copy to bank 1
        clear_log();
        mixpsel = 1'b1;
        pulse_req(3);
        wait_done(1, "t1 timeout");
        repeat (5) @(negedge clk);
        chk("t1 writes", 32'(wr_n), 16);
        chk("t1 done", 32'(done_n), 1);
        chk("t1 busy clocks", 32'(busy_n), 18);
        chk("t1 first write latency", 32'(wr_cyc[0] - t_req), 4);
        chk("t1 done latency", 32'(done_cyc - t_req), 20);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t1 addr %0d", i), 32'(wr_addr[i]), 32'(16 + i));
            chk($sformatf("t1 data %0d", i), 32'(wr_data[i]), 32'(16'hA500 + i));
            chk($sformatf("t1 cycle %0d", i), 32'(wr_cyc[i] - wr_cyc[0]), 32'(i));
        end

        // held request level: one copy only
        clear_log();
        mixpsel = 1'b0;
        pulse_req(40);
        repeat (20) @(negedge clk);
        chk("t2 writes", 32'(wr_n), 16);
        chk("t2 done", 32'(done_n), 1);
        chk("t2 first addr", 32'(wr_addr[0]), 0);
        chk("t2 last addr", 32'(wr_addr[15]), 15);

        // re-requests during copies, extra request dropped
        clear_log();
        mixpsel = 1'b0;
        pulse_req(1);
        wait_wr(5, "t3 wait w5");
        mixpsel = 1'b1;
        pulse_req(1);
        wait_wr(20, "t3 wait w20");
        mixpsel = 1'b0;
        pulse_req(1);
        wait_wr(24, "t3 wait w24");
        pulse_req(1);
        wait_done(3, "t3 timeout");
        repeat (40) @(negedge clk);
        chk("t3 writes", 32'(wr_n), 48);
        chk("t3 done", 32'(done_n), 3);
        for (int i = 0; i < 48; i++) begin
            chk($sformatf("t3 addr %0d", i), 32'(wr_addr[i]), 32'((i < 32) ? i : i - 32));
            chk($sformatf("t3 data %0d", i), 32'(wr_data[i]), 32'(16'hA500 + (i % 16)));
        end

        // cen every 4th clock
        clear_log();
        gate_cen = 1'b1;
        mixpsel  = 1'b1;
        pulse_req(1);
        wait_done(1, "t4 timeout");
        repeat (5) @(negedge clk);
        gate_cen = 1'b0;
        chk("t4 writes", 32'(wr_n), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4 addr %0d", i), 32'(wr_addr[i]), 32'(16 + i));
            chk($sformatf("t4 data %0d", i), 32'(wr_data[i]), 32'(16'hA500 + i));
            if (i > 0)
                chk($sformatf("t4 spacing %0d", i), 32'(wr_cyc[i] - wr_cyc[i-1]), 4);
        end

        // reset in the middle of a copy
        clear_log();
        mixpsel = 1'b0;
        pulse_req(1);
        wait_wr(7, "t5 wait w7");
        #3 rst = 1'b1;
        #1;
        chk("t5 async buf_we", 32'(buf_we), 0);
        chk("t5 async busy", 32'(busy), 0);
        chk("t5 async done", 32'(done), 0);
        n_at = wr_n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t5 no writes after reset", 32'(wr_n), 32'(n_at));
        chk("t5 no done after reset", 32'(done_n), 0);
        pulse_req(1);
        wait_done(1, "t5 timeout");
        repeat (5) @(negedge clk);
        chk("t5 new copy writes", 32'(wr_n - n_at), 16);

`ifdef JTCOP_OBJDMA_VBWAIT_EN
        // copy held off until vertical blank, continues past its end
        clear_log();
        LVBL    = 1'b1;
        mixpsel = 1'b1;
        pulse_req(1);
        repeat (20) @(negedge clk);
        chk("vb no writes outside blank", 32'(wr_n), 0);
        chk("vb busy while waiting", 32'(busy), 1);
        LVBL  = 1'b0;
        t_req = cyc;
        wait_wr(5, "vb wait w5");
        LVBL = 1'b1;
        wait_done(1, "vb timeout");
        repeat (5) @(negedge clk);
        chk("vb first write latency", 32'(wr_cyc[0] - t_req), 3);
        chk("vb writes", 32'(wr_n), 16);
        chk("vb last addr", 32'(wr_addr[15]), 31);
        chk("vb last data", 32'(wr_data[15]), 32'h0000A50F);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
